// File: rtl/bbtron_pkg.sv
// Shared constants, state encoding and small helpers for the bbtron fetch stage.
package bbtron_pkg;

   localparam int ADDR_W     = 10;
   localparam int INSTR_W    = 32;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int CNT_W      = 32;

   localparam logic [5:0]        HALT_OPCODE      = 6'h3F;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 10'd0;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return (instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of memory, control and decode-side signals of the fetch stage.
// The fetch_count member exists only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if;
   import bbtron_pkg::*;

   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] mem_data;
   logic               stall;
   logic               branch_taken;
   logic [ADDR_W-1:0]  branch_target;
   logic               resume;
   logic [INSTR_W-1:0] instr_out;
   logic [ADDR_W-1:0]  pc_out;
   logic               instr_valid;
   logic               halted;
`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0]   fetch_count;

   modport master (
      output mem_addr, instr_out, pc_out, instr_valid, halted, fetch_count,
      input  mem_data, stall, branch_taken, branch_target, resume
   );
   modport slave (
      input  mem_addr, instr_out, pc_out, instr_valid, halted, fetch_count,
      output mem_data, stall, branch_taken, branch_target, resume
   );
`else
   modport master (
      output mem_addr, instr_out, pc_out, instr_valid, halted,
      input  mem_data, stall, branch_taken, branch_target, resume
   );
   modport slave (
      input  mem_addr, instr_out, pc_out, instr_valid, halted,
      output mem_data, stall, branch_taken, branch_target, resume
   );
`endif

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load has priority over increment; increment wraps
// modulo 2^ADDR_W.
module pc_reg
   import bbtron_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   // Next PC selection
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end else if (inc_en) begin
         pc_d = pc_q + 10'd1;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC register
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, branch flush, stall hold and HALT/resume control.
// Define FETCH_PERF_CNT_EN to add a saturating count of accepted instructions.
module fetch_unit
   import bbtron_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);

   fetch_state_t       state_d,     state_q;
   logic [INSTR_W-1:0] instr_out_d, instr_out_q;
   logic [ADDR_W-1:0]  pc_out_d,    pc_out_q;
   logic               valid_d,     valid_q;
   logic               halted_d,    halted_q;
   logic               pc_load;
   logic               pc_inc;
   logic               accept;
   logic [ADDR_W-1:0]  pc;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock    (clock),
      .reset    (reset),
      .load_en  (pc_load),
      .load_val (bus.branch_target),
      .inc_en   (pc_inc),
      .pc       (pc)
   );

   // Control FSM next-state and output-register next values
   always_comb begin
      state_d     = state_q;
      instr_out_d = instr_out_q;
      pc_out_d    = pc_out_q;
      valid_d     = valid_q;
      halted_d    = halted_q;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      accept      = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.branch_taken) begin
               // wrong-path word still loads, but is never marked valid
               pc_load     = 1'b1;
               instr_out_d = bus.mem_data;
               pc_out_d    = pc;
               valid_d     = 1'b0;
            end else if (bus.stall) begin
               valid_d = valid_q;
            end else begin
               accept      = 1'b1;
               pc_inc      = 1'b1;
               instr_out_d = bus.mem_data;
               pc_out_d    = pc;
               valid_d     = 1'b1;
               if (is_halt(bus.mem_data)) begin
                  state_d  = HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  halted_d = 1'b0;
               end
            end
         end
         HALTED: begin
            valid_d = 1'b0;
            pc_load = bus.branch_taken;
            if (bus.resume) begin
               state_d  = RUN;
               halted_d = 1'b0;
            end else begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end
         end
         default: begin
            state_d  = RUN;
            valid_d  = 1'b0;
            halted_d = 1'b0;
         end
      endcase
   end

   // State and decode-side output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= RUN;
         instr_out_q <= 32'h0000_0000;
         pc_out_q    <= 10'd0;
         valid_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_out_q <= instr_out_d;
         pc_out_q    <= pc_out_d;
         valid_q     <= valid_d;
         halted_q    <= halted_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] fetch_count_d, fetch_count_q;

   // Saturating count of accepted instructions
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (accept) begin
         fetch_count_d = sat_inc(fetch_count_q);
      end else begin
         fetch_count_d = fetch_count_q;
      end
   end

   // Performance counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count_q <= 32'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.fetch_count = fetch_count_q;
`endif

   assign bus.mem_addr    = pc;
   assign bus.instr_out   = instr_out_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver queues hand-computed expectations
// per clock edge, and a negedge monitor pops and compares them.
module tb_fetch_unit;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] instr;
      logic [9:0]  pc;
      logic        valid;
      logic        halted;
      logic        cnt_chk;
      logic [31:0] cnt;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mem [1024];
   exp_t        exp_q [$];
   int          checks   = 0;
   int          failures = 0;
   logic        nxt_cnt_chk = 1'b0;
   logic [31:0] nxt_cnt     = 32'd0;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.mem_data = mem[bus.mem_addr];

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, take the edge, queue the state expected after it
   task automatic c(input logic rst, input logic st, input logic br, input logic [9:0] tgt,
                    input logic rs, input logic [9:0] ea, input logic [31:0] ei,
                    input logic [9:0] ep, input logic ev, input logic eh);
      exp_t e;
      reset             = rst;
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      bus.resume        = rs;
      @(posedge clock);
      e.addr    = ea;
      e.instr   = ei;
      e.pc      = ep;
      e.valid   = ev;
      e.halted  = eh;
      e.cnt_chk = nxt_cnt_chk;
      e.cnt     = nxt_cnt;
      exp_q.push_back(e);
      nxt_cnt_chk = 1'b0;
      #1;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mem_addr",    {22'd0, bus.mem_addr}, {22'd0, e.addr});
         chk("instr_out",   bus.instr_out,         e.instr);
         chk("pc_out",      {22'd0, bus.pc_out},   {22'd0, e.pc});
         chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, e.valid});
         chk("halted",      {31'd0, bus.halted},   {31'd0, e.halted});
`ifdef FETCH_PERF_CNT_EN
         if (e.cnt_chk) begin
            chk("fetch_count", bus.fetch_count, e.cnt);
         end
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0011 + i;
      reset = 1'b1;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 10'd0; bus.resume = 1'b0;

      // reset for two cycles, then sequential fetch 0..4
      c(1,0,0,10'd0,0, 10'd0, 32'h0,  10'd0, 0,0);
      c(1,0,0,10'd0,0, 10'd0, 32'h0,  10'd0, 0,0);
      c(0,0,0,10'd0,0, 10'd1, 32'h11, 10'd0, 1,0);
      c(0,0,0,10'd0,0, 10'd2, 32'h12, 10'd1, 1,0);
      c(0,0,0,10'd0,0, 10'd3, 32'h13, 10'd2, 1,0);
      c(0,0,0,10'd0,0, 10'd4, 32'h14, 10'd3, 1,0);
      c(0,0,0,10'd0,0, 10'd5, 32'h15, 10'd4, 1,0);
      // stall three cycles at pc=5
      repeat (3) c(0,1,0,10'd0,0, 10'd5, 32'h15, 10'd4, 1,0);
      c(0,0,0,10'd0,0, 10'd6, 32'h16, 10'd5, 1,0);
      c(0,0,0,10'd0,0, 10'd7, 32'h17, 10'd6, 1,0);
      // branch at pc=7, then branch with stall at pc=0x201
      c(0,0,1,10'h200,0, 10'h200, 32'h18,  10'd7,   0,0);
      c(0,0,0,10'd0,0,   10'h201, 32'h211, 10'h200, 1,0);
      c(0,1,1,10'h300,0, 10'h300, 32'h212, 10'h201, 0,0);
      c(0,0,0,10'd0,0,   10'h301, 32'h311, 10'h300, 1,0);
      // wrap through 1023
      c(0,0,1,10'h3FE,0, 10'h3FE, 32'h312, 10'h301, 0,0);
      c(0,0,0,10'd0,0,   10'h3FF, 32'h40F, 10'h3FE, 1,0);
      c(0,0,0,10'd0,0,   10'd0,   32'h410, 10'h3FF, 1,0);
      c(0,0,0,10'd0,0,   10'd1,   32'h11,  10'd0,   1,0);
      c(0,0,0,10'd0,0,   10'd2,   32'h12,  10'd1,   1,0);
      // halt word at 3; a stall while it is presented must not halt
      mem[3] = 32'hFC00_0000;
      c(0,0,0,10'd0,0, 10'd3, 32'h13, 10'd2, 1,0);
      c(0,1,0,10'd0,0, 10'd3, 32'h13, 10'd2, 1,0);
      c(0,0,0,10'd0,0, 10'd4, 32'hFC00_0000, 10'd3, 1,1);
      for (int i = 0; i < 5; i++) c(0,i[0],0,10'd0,0, 10'd4, 32'hFC00_0000, 10'd3, 0,1);
      c(0,0,0,10'd0,1, 10'd4, 32'hFC00_0000, 10'd3, 0,0);
      c(0,0,0,10'd0,0, 10'd5, 32'h15,        10'd4, 1,0);
      // halt again, then resume together with a branch
      c(0,0,1,10'd3,0,    10'd3,   32'h16,        10'd5,   0,0);
      c(0,0,0,10'd0,0,    10'd4,   32'hFC00_0000, 10'd3,   1,1);
      c(0,0,1,10'h10,1,   10'h10,  32'hFC00_0000, 10'd3,   0,0);
      c(0,0,0,10'd0,0,    10'h11,  32'h21,        10'h10,  1,0);
      // halt, branch while halted (stays halted), then reset from HALTED
      c(0,0,1,10'd3,0,    10'd3,   32'h22,        10'h11,  0,0);
      c(0,0,0,10'd0,0,    10'd4,   32'hFC00_0000, 10'd3,   1,1);
      c(0,0,1,10'h20,0,   10'h20,  32'hFC00_0000, 10'd3,   0,1);
      c(1,0,0,10'd0,0,    10'd0,   32'h0,         10'd0,   0,0);
      mem[3] = 32'h0000_0014;
      // reset wins over branch; counter cleared
      nxt_cnt_chk = 1'b1; nxt_cnt = 32'd0;
      c(1,0,1,10'h155,0,  10'd0,   32'h0,         10'd0,   0,0);
      // ten accepted fetches with two stall cycles, then one flushed branch
      for (int k = 1; k <= 10; k++) begin
         c(0,0,0,10'd0,0, 10'(k), 32'h11 + 32'(k - 1), 10'(k - 1), 1,0);
         if (k == 5) repeat (2) c(0,1,0,10'd0,0, 10'd5, 32'h15, 10'd4, 1,0);
      end
      nxt_cnt_chk = 1'b1; nxt_cnt = 32'd10;
      c(0,0,1,10'd0,0, 10'd0, 32'h1B, 10'd10, 0,0);
      nxt_cnt_chk = 1'b1; nxt_cnt = 32'd0;
      c(1,0,0,10'd0,0, 10'd0, 32'h0,  10'd0,  0,0);

      @(negedge clock);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
